// File: rtl/turn_controller.sv
// Connect Four turn sequencer: validates column requests, steps one column
// counter per accepted move, writes the board cell and decides win/draw.
module turn_controller #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_valid,
    input  logic [3:0]        move_col,
    output logic              move_ready,
    input  logic [3*COLS-1:0] col_counts,
    input  logic              win_in,
    output logic [3:0]        drop_col,
    output logic              wr_en,
    output logic [2:0]        wr_row,
    output logic [3:0]        wr_col,
    output logic              wr_player,
    output logic              player,
    output logic              reject,
    output logic              game_over,
    output logic              winner,
    output logic              draw
);

    localparam logic [5:0] CELLS = 6'(COLS * ROWS);

    typedef enum logic [2:0] {
        IDLE,
        DROP,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t     state, state_d;
    logic [3:0] col_q, col_d;
    logic [2:0] row_q, row_d;
    logic [5:0] cnt_q, cnt_d;
    logic       player_d, reject_d, winner_d, draw_d;
    logic [2:0] sel_cnt;
    logic       legal;

    // Out-of-range indices select nothing, so the slice never overruns.
    always_comb begin
        sel_cnt = '0;
        for (int c = 0; c < COLS; c++) begin
            if (move_col == 4'(c)) sel_cnt = col_counts[3*c +: 3];
        end
        legal = (move_col < 4'(COLS)) && (sel_cnt < 3'(ROWS));
    end

    always_comb begin
        state_d    = state;
        col_d      = col_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        player_d   = player;
        reject_d   = 1'b0;
        winner_d   = winner;
        draw_d     = draw;
        move_ready = (state == IDLE);
        game_over  = (state == DONE);
        drop_col   = 4'hF;
        wr_en      = 1'b0;
        wr_row     = '0;
        wr_col     = '0;
        wr_player  = 1'b0;
        unique case (state)
            IDLE: begin
                if (move_valid) begin
                    if (legal) begin
                        col_d   = move_col;
                        row_d   = sel_cnt;
                        state_d = DROP;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            DROP: begin
                drop_col  = col_q;
                wr_en     = 1'b1;
                wr_row    = row_q;
                wr_col    = col_q;
                wr_player = player;
                if (cnt_q != CELLS) cnt_d = cnt_q + 6'd1;
                state_d = SETTLE;
            end
            SETTLE: state_d = CHECK;
            CHECK: begin
                // A win on the final cell outranks the draw.
                if (win_in) begin
                    winner_d = player;
                    state_d  = DONE;
                end else if (cnt_q == CELLS) begin
                    draw_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    player_d = ~player;
                    state_d  = IDLE;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            col_q  <= '0;
            row_q  <= '0;
            cnt_q  <= '0;
            player <= 1'b0;
            reject <= 1'b0;
            winner <= 1'b0;
            draw   <= 1'b0;
        end else begin
            state  <= state_d;
            col_q  <= col_d;
            row_q  <= row_d;
            cnt_q  <= cnt_d;
            player <= player_d;
            reject <= reject_d;
            winner <= winner_d;
            draw   <= draw_d;
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// Randomized bench for turn_controller against a move-level board model,
// with a behavioural column counter bank driven by drop_col.
module tb_turn_controller;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              move_valid;
    logic [3:0]        move_col;
    logic              move_ready;
    logic [3*COLS-1:0] col_counts;
    logic              win_in;
    logic [3:0]        drop_col;
    logic              wr_en;
    logic [2:0]        wr_row;
    logic [3:0]        wr_col;
    logic              wr_player;
    logic              player;
    logic              reject;
    logic              game_over;
    logic              winner;
    logic              draw;

    int n_cmp = 0;
    int n_bad = 0;

    int bank[COLS];
    int mh[COLS];
    int mn;
    bit mp;
    bit mover;

    turn_controller #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .reset(reset), .move_valid(move_valid),
        .move_col(move_col), .move_ready(move_ready),
        .col_counts(col_counts), .win_in(win_in), .drop_col(drop_col),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_player(wr_player), .player(player), .reject(reject),
        .game_over(game_over), .winner(winner), .draw(draw)
    );

    always #5 clk = ~clk;

    // Column counter bank: increments whenever its index is on drop_col.
    always @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < COLS; c++) bank[c] <= 0;
        end else if (drop_col < 4'(COLS)) begin
            bank[int'(drop_col)] <= bank[int'(drop_col)] + 1;
        end
    end

    always_comb begin
        col_counts = '0;
        for (int c = 0; c < COLS; c++) col_counts[3*c +: 3] = 3'(bank[c]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < COLS; c++) mh[c] = 0;
        mn = 0;
        mp = 1'b0;
        mover = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        move_valid = 1'b0;
        move_col = 4'd0;
        win_in = 1'b0;
        step();
        step();
        reset = 1'b1;
        model_clear();
    endtask

    // One move at transaction level; checks every cycle of its timeline.
    task automatic move(input int col, input bit win, input bit hold);
        bit legal;
        logic [14:0] obs, exp;
        logic [6:0] sobs, sexp;
        legal = 1'b0;
        if (col < COLS) legal = (mh[col] < ROWS);
        n_cmp++;
        if ({move_ready, player} !== {1'b1, mp}) begin
            n_bad++;
            $display("FAIL pre_move: got %b expected %b",
                     {move_ready, player}, {1'b1, mp});
        end
        move_valid = 1'b1;
        move_col = 4'(col);
        win_in = win;
        step();
        if (!hold) move_valid = 1'b0;
        if (legal) begin
            obs = {move_ready, reject, drop_col, wr_en, wr_row, wr_col, wr_player};
            exp = {1'b0, 1'b0, 4'(col), 1'b1, 3'(mh[col]), 4'(col), mp};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL drop col%0d: got %h expected %h", col, obs, exp);
            end
            mh[col]++;
            mn++;
            for (int k = 0; k < 2; k++) begin
                step();
                n_cmp++;
                if ({move_ready, reject, drop_col, wr_en} !== 7'b00_1111_0) begin
                    n_bad++;
                    $display("FAIL busy%0d: got %b expected 0011110", k,
                             {move_ready, reject, drop_col, wr_en});
                end
            end
            n_cmp++;
            if (bank[col] !== mh[col]) begin
                n_bad++;
                $display("FAIL count col%0d: got %0d expected %0d",
                         col, bank[col], mh[col]);
            end
            step();
            move_valid = 1'b0;
            if (win) begin
                mover = 1'b1;
                sexp = {1'b1, mp, 1'b0, 1'b0, mp, 1'b0, 1'b0};
            end else if (mn == COLS * ROWS) begin
                mover = 1'b1;
                sexp = {1'b1, 1'b0, 1'b1, 1'b0, mp, 1'b0, 1'b0};
            end else begin
                mp = ~mp;
                sexp = {1'b0, 1'b0, 1'b0, 1'b1, mp, 1'b0, 1'b0};
            end
            sobs = {game_over, winner, draw, move_ready, player, reject, wr_en};
            n_cmp++;
            if (sobs !== sexp) begin
                n_bad++;
                $display("FAIL after col%0d: got %b expected %b", col, sobs, sexp);
            end
        end else begin
            n_cmp++;
            if ({move_ready, reject, drop_col, wr_en, player} !== {8'b11_1111_0, mp}) begin
                n_bad++;
                $display("FAIL reject col%0d: got %b expected %b", col,
                         {move_ready, reject, drop_col, wr_en, player},
                         {8'b11_1111_0, mp});
            end
            move_valid = 1'b0;
            step();
            n_cmp++;
            if ({reject, drop_col, player} !== {5'b0_1111, mp}) begin
                n_bad++;
                $display("FAIL reject_end col%0d: got %b expected %b", col,
                         {reject, drop_col, player}, {5'b0_1111, mp});
            end
        end
        win_in = 1'b0;
    endtask

    task automatic fill_to(input int n, input bit last_win);
        int c;
        while (mn < n && !mover) begin
            c = int'($urandom_range(0, COLS - 1));
            while (mh[c] >= ROWS) c = (c + 1) % COLS;
            move(c, last_win && (mn == n - 1), bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic check_done_ignores(input bit w, input bit d);
        move_valid = 1'b1;
        move_col = 4'($urandom_range(0, COLS - 1));
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if ({move_ready, reject, drop_col, wr_en, game_over, winner, draw}
                !== {7'b00_1111_0, 1'b1, w, d}) begin
                n_bad++;
                $display("FAIL done_hold%0d: got %b expected %b", k,
                         {move_ready, reject, drop_col, wr_en, game_over, winner, draw},
                         {7'b00_1111_0, 1'b1, w, d});
            end
        end
        move_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        move_valid = 1'b1;
        move_col = 4'd1;
        win_in = 1'b0;
        step();
        step();
        n_cmp++;
        if ({player, drop_col, move_ready, wr_en, reject, game_over, winner, draw}
            !== 11'b0_1111_1_00000) begin
            n_bad++;
            $display("FAIL reset: got %b expected 01111100000",
                     {player, drop_col, move_ready, wr_en, reject, game_over, winner, draw});
        end
        move_valid = 1'b0;
        reset = 1'b1;
        model_clear();
        step();
    endtask

    task automatic test_legal_move();
        move(3, 1'b0, 1'b0);
    endtask

    task automatic test_full_column();
        do_reset();
        for (int i = 0; i < ROWS; i++) move(2, 1'b0, 1'b0);
        move(2, 1'b0, 1'b0);
        n_cmp++;
        if (bank[2] !== ROWS) begin
            n_bad++;
            $display("FAIL full_count: got %0d expected %0d", bank[2], ROWS);
        end
    endtask

    task automatic test_bad_index();
        move(7, 1'b0, 1'b0);
        move(15, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        move(4, 1'b0, 1'b1);
        move(4, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            move(int'($urandom_range(0, 15)), 1'b0, bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_win();
        do_reset();
        move(0, 1'b0, 1'b0);
        move(1, 1'b1, 1'b0);
        check_done_ignores(1'b1, 1'b0);
    endtask

    task automatic test_win_on_full();
        do_reset();
        fill_to(COLS * ROWS, 1'b1);
        check_done_ignores(mp, 1'b0);
    endtask

    task automatic test_draw_then_reset();
        do_reset();
        fill_to(COLS * ROWS, 1'b0);
        check_done_ignores(1'b0, 1'b1);
        do_reset();
        move_valid = 1'b1;
        move_col = 4'd5;
        step();
        move_valid = 1'b0;
        n_cmp++;
        if ({drop_col, wr_en} !== 5'b0101_1) begin
            n_bad++;
            $display("FAIL new_drop: got %b expected 01011", {drop_col, wr_en});
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({player, drop_col, move_ready, wr_en, reject, game_over, winner, draw}
            !== 11'b0_1111_1_00000) begin
            n_bad++;
            $display("FAIL mid_reset: got %b expected 01111100000",
                     {player, drop_col, move_ready, wr_en, reject, game_over, winner, draw});
        end
        reset = 1'b1;
        model_clear();
        step();
        n_cmp++;
        if ({drop_col, wr_en, move_ready, bank[5]} !== {6'b1111_0_1, 32'd0}) begin
            n_bad++;
            $display("FAIL post_reset: got %b/%0d expected 111101/0",
                     {drop_col, wr_en, move_ready}, bank[5]);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_legal_move();
        test_full_column();
        test_bad_index();
        test_back_to_back();
        test_random();
        test_win();
        test_win_on_full();
        test_draw_then_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
